// File: rtl/proc_control_unit_if.sv
// Bus between the Run/DIN source and the processor control unit.
// CTRL_MVNZ_EN adds the Gnz status input used by the mvnz opcode.
interface proc_control_unit_if;
  logic       Run;
  logic [8:0] DIN;
`ifdef CTRL_MVNZ_EN
  logic       Gnz;
`endif
  logic [9:0] sel;
  logic [7:0] Rin;
  logic       IRin;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;

  modport master (
`ifdef CTRL_MVNZ_EN
    output Gnz,
`endif
    output Run, DIN,
    input  sel, Rin, IRin, Ain, Gin, AddSub, Done
  );

  modport slave (
`ifdef CTRL_MVNZ_EN
    input  Gnz,
`endif
    input  Run, DIN,
    output sel, Rin, IRin, Ain, Gin, AddSub, Done
  );
endinterface

// File: rtl/proc_control_unit.sv
// T0-T3 step control unit for the 9-bit bus processor (mv, mvi, add, sub).
// Optional macro CTRL_MVNZ_EN turns opcode 100 into mvnz (conditional move on Gnz).
module proc_control_unit (
  input  logic                 clk,
  input  logic                 rst,
  proc_control_unit_if.slave   bus
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [9:0] SEL_DIN = 10'b10_0000_0000;
  localparam logic [9:0] SEL_G   = 10'b00_0000_0001;

  state_t     state;
  logic [8:0] ir;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_arith;

  logic [9:0] sel;
  logic [7:0] rin;
  logic       irin;
  logic       ain;
  logic       gin;
  logic       addsub;
  logic       done;

  // Rk drives bus select bit (8-k)
  function automatic logic [9:0] reg_sel(input logic [2:0] k);
    return 10'b1 << (4'd8 - {1'b0, k});
  endfunction

  function automatic logic [7:0] reg_en(input logic [2:0] k);
    return 8'b1 << k;
  endfunction

  assign opcode   = ir[8:6];
  assign rx       = ir[5:3];
  assign ry       = ir[2:0];
  assign is_arith = (opcode == 3'b010) || (opcode == 3'b011);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T0;
      ir    <= 9'b0;
    end else begin
      if (irin) ir <= bus.DIN;
      case (state)
        T0:      state <= bus.Run ? T1 : T0;
        T1:      state <= is_arith ? T2 : T0;
        T2:      state <= T3;
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    sel    = SEL_DIN;
    rin    = 8'b0;
    irin   = 1'b0;
    ain    = 1'b0;
    gin    = 1'b0;
    addsub = 1'b0;
    done   = 1'b0;
    case (state)
      T0: irin = bus.Run;
      T1: begin
        case (opcode)
          3'b000: begin
            sel  = reg_sel(ry);
            rin  = reg_en(rx);
            done = 1'b1;
          end
          3'b001: begin
            rin  = reg_en(rx);
            done = 1'b1;
          end
          3'b010, 3'b011: begin
            sel = reg_sel(rx);
            ain = 1'b1;
          end
`ifdef CTRL_MVNZ_EN
          3'b100: begin
            sel  = reg_sel(ry);
            rin  = bus.Gnz ? reg_en(rx) : 8'b0;
            done = 1'b1;
          end
`endif
          default: done = 1'b1;
        endcase
      end
      T2: begin
        sel    = reg_sel(ry);
        gin    = 1'b1;
        addsub = opcode[0];
      end
      T3: begin
        sel  = SEL_G;
        rin  = reg_en(rx);
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.sel    = sel;
  assign bus.Rin    = rin;
  assign bus.IRin   = irin;
  assign bus.Ain    = ain;
  assign bus.Gin    = gin;
  assign bus.AddSub = addsub;
  assign bus.Done   = done;

endmodule

// File: doc/proc_control_unit.md
# proc_control_unit

Control unit for the 9-bit bus processor; it drives the one-hot bus select consumed by the 10:1 bus multiplexer. Instructions are fetched from DIN into an internal instruction register. A T0–T3 step FSM then issues the register, accumulator and result enables, the add/subtract control, and the bus select needed to execute each instruction. It sits between the external Run/DIN source and the register file, bus mux and adder.

## Interface
Parameters: none.
- Clock  in  1  rising-edge clock, sole clock domain
- Reset  in  1  synchronous, active-high; forces T0 and clears IR
- Run  in  1  start request; sampled only in T0
- DIN  in  9  instruction word, format III XXX YYY (opcode, dest RX, src RY)
- Gnz  in  1  G register non-zero; present only with CTRL_MVNZ_EN
- sel  out  10  one-hot bus select: bit9=DIN, bit8=R0 … bit1=R7, bit0=G
- Rin  out  8  register write enables, Rin[k] loads Rk
- IRin  out  1  instruction-register load strobe (observability)
- Ain  out  1  A register load
- Gin  out  1  G register load
- AddSub  out  1  0=add, 1=subtract
- Done  out  1  single-cycle completion pulse

## Operation
- IR: 9-bit register, loaded from DIN when IRin=1; reset value 9'b0.
- Step counter: 2-bit state T0..T3; reset value T0.
- Opcodes:
  - 000 mv: RX ← RY
  - 001 mvi: RX ← DIN
  - 010 add: RX ← RX+RY
  - 011 sub: RX ← RX−RY
  - 1xx: NOP, except 100 with the macro enabled.
- Select encoding: Rk maps to sel bit (8−k); all outputs are combinational decodes of state and IR, IRin additionally of Run.
- T0: sel=DIN. If Run=1: IRin=1, next state T1. Otherwise stay in T0 with all enables 0.
- T1:
  - mv: sel=RY, Rin[X]=1, Done=1, next T0.
  - mvi: sel=DIN, Rin[X]=1, Done=1, next T0.
  - add/sub: sel=RX, Ain=1, next T2.
  - NOP: sel=DIN, no enables, Done=1, next T0.
- T2 (add/sub only): sel=RY, Gin=1, AddSub=1 for sub and 0 for add, next T3.
- T3: sel=G, Rin[X]=1, Done=1, next T0.
- Run outside T0 is ignored. A held Run starts a new fetch in the T0 that follows Done.
- Exactly one sel bit is set in every state. At most one Rin bit is set.
- X=Y is legal, e.g. add R2,R2 doubles R2.

## Timing
- Reset values of outputs (state T0, Run=0): sel=10'b1000000000, all other outputs 0.
- Reset has priority over Run on the same edge. Reset mid-instruction aborts the instruction: no further enables are issued, Done is not pulsed, and IR=0 after the edge.
- Latency from the Run-sampling edge to the Done cycle:
  - mv, mvi, NOP: Done in the 1st cycle after the edge (2 cycles total including fetch).
  - add, sub: Done in the 3rd cycle after the edge (4 cycles total).
- Back-to-back: with Run held high, the next fetch occurs the cycle after Done, giving no idle gap beyond T0.
- All enables act on the rising edge that ends the cycle in which they are asserted.

## Configuration
- CTRL_MVNZ_EN defined: Gnz port exists and opcode 100 is mvnz.
  - In T1 sel=RY and Done=1.
  - Rin[X]=1 only if Gnz=1; otherwise no register write.
  - The instruction always takes the same 2 cycles.
- Undefined: the Gnz port is absent and opcode 100 behaves as NOP.

## Test plan
- Reset held 2 cycles with Run=1 → state T0, IR=0, sel=10'b1000000000, Done=0 and no enables after release.
- Run=1, DIN=9'b001_011_000 (mvi R3) → next cycle sel=10'b1000000000, Rin=8'b00001000, Done=1; then T0.
- Run=1, DIN=9'b000_001_110 (mv R1,R6) → sel=10'b0000000100, Rin=8'b00000010, Done=1 in the 2nd cycle.
- Run=1, DIN=9'b011_000_101 (sub R0,R5) → T1: sel bit8 and Ain. T2: sel bit3, Gin, AddSub=1. T3: sel bit0, Rin=8'b00000001, Done. Run toggled during T1–T3 has no effect.
- Reset asserted during T2 of an add → after the edge state T0, IR=0, Gin/Rin/Done stay 0; the next Run fetches normally.
- With CTRL_MVNZ_EN, DIN=9'b100_010_100: Gnz=0 → Rin=0 with Done=1; Gnz=1 → Rin=8'b00000100 with Done=1.
